// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and helpers for the dmem_sync_port data memory.
//               - Access-size encodings
//               - FSM state encoding
//               - Byte-enable helper that maps size and addr[1:0] to lanes
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    // Little-endian lane selection. Misaligned combinations are rejected
    // before this result is used, so only the lane position matters here.
    function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                                input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_WORD: be = 4'b1111;
            SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: be = 4'b0001 << lo;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_sync_port_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sync_port_if
// Description : Request/response bundle between the load/store unit and the
//               data memory.
//               Request : req_valid, req_ready, req_we, req_size, req_sext,
//                         req_addr, req_wdata
//               Response: rsp_valid (1-cycle pulse), rsp_rdata, rsp_err
//               master = load/store unit side, slave = memory side
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_sync_port_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface
`default_nettype wire

// File: rtl/dmem_lane_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_ram
// Description : DEPTH_WORDS x 32 storage with per-byte write enables and a
//               registered read port.
//   clk   in   rising-edge clock
//   addr  in   word index
//   we    in   byte-lane write enables, lane k = bits [8k+7:8k]
//   wdata in   write data, already steered into lanes
//   re    in   read enable; rdata holds its value while re is low
//   rdata out  registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_ram #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    AW          = 10,
    parameter string INIT_FILE   = ""
) (
    input  wire logic          clk,
    input  wire logic [AW-1:0] addr,
    input  wire logic [3:0]    we,
    input  wire logic [31:0]   wdata,
    input  wire logic          re,
    output logic      [31:0]   rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Storage is deliberately not reset: contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_sync_port.sv
`default_nettype none
// ============================================================================
// Module      : dmem_sync_port
// Description : Synchronous word-organised data memory with valid/ready
//               request port and a one-cycle response pulse. Supports
//               word/half/byte loads and stores with sign/zero extension;
//               misaligned, out-of-range and illegal-size accesses are
//               flagged with rsp_err and never touch the RAM.
//   clk  in      rising-edge clock
//   rst  in      synchronous active-high reset
//   bus  slave   request/response bundle (dmem_sync_port_if)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_sync_port
    import dmem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    READ_LAT    = 1,
    parameter string INIT_FILE   = ""
) (
    input  wire logic   clk,
    input  wire logic   rst,
    dmem_sync_port_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    state_t      r_state;
    state_t      w_state_nxt;

    // Request fields captured at accept
    logic        r_we;
    logic        r_err;
    logic [1:0]  r_size;
    logic        r_sext;
    logic [1:0]  r_lo;

    logic        w_accept;
    logic        w_misalign;
    logic        w_oor;
    logic        w_err;
    logic [3:0]  w_ram_we;
    logic        w_ram_re;
    logic [31:0] w_ram_wdata;
    logic [31:0] w_ram_rdata;
    logic [31:0] w_rd_src;
    logic [31:0] w_load_data;
    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // ------------------------------------------------------------------
    // Request decode and checks
    // ------------------------------------------------------------------
    assign bus.req_ready = !rst && (r_state != ST_RD_WAIT);
    assign w_accept      = bus.req_valid && bus.req_ready;

    always_comb begin
        w_misalign = 1'b0;
        case (bus.req_size)
            SZ_WORD: w_misalign = (bus.req_addr[1:0] != 2'b00);
            SZ_HALF: w_misalign = bus.req_addr[0];
            SZ_BYTE: w_misalign = 1'b0;
            default: w_misalign = 1'b1;     // illegal size folds in here
        endcase
    end

    assign w_oor = (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_err = w_misalign || w_oor;

    // Replicate narrow store data across all lanes; the byte enables pick
    // the lane(s) that actually get written.
    always_comb begin
        w_ram_wdata = bus.req_wdata;
        case (bus.req_size)
            SZ_HALF: w_ram_wdata = {2{bus.req_wdata[15:0]}};
            SZ_BYTE: w_ram_wdata = {4{bus.req_wdata[7:0]}};
            default: w_ram_wdata = bus.req_wdata;
        endcase
    end

    assign w_ram_we = (w_accept && bus.req_we && !w_err)
                    ? byte_enables(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
    assign w_ram_re = w_accept && !bus.req_we && !w_err;

    dmem_lane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .addr  (bus.req_addr[AW+1:2]),
        .we    (w_ram_we),
        .wdata (w_ram_wdata),
        .re    (w_ram_re),
        .rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Read latency: with two cycles the RAM output is re-registered during
    // RD_WAIT so the response is driven from a flop one stage later.
    // ------------------------------------------------------------------
    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [31:0] r_rdata_d;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata_d <= 32'h0;
                end else begin
                    r_rdata_d <= w_ram_rdata;
                end
            end
            assign w_rd_src = r_rdata_d;
        end else begin : g_lat1
            assign w_rd_src = w_ram_rdata;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_size  <= SZ_WORD;
            r_sext  <= 1'b0;
            r_lo    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we   <= bus.req_we;
                r_err  <= w_err;
                r_size <= bus.req_size;
                r_sext <= bus.req_sext;
                r_lo   <= bus.req_addr[1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    if (bus.req_we || w_err || (READ_LAT == 1)) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_state_nxt = ST_RD_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_WAIT: w_state_nxt = ST_RESP;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Load lane select and extension
    // ------------------------------------------------------------------
    assign w_half = r_lo[1] ? w_rd_src[31:16] : w_rd_src[15:0];
    assign w_byte = w_rd_src[8*r_lo +: 8];

    always_comb begin
        w_load_data = w_rd_src;
        case (r_size)
            SZ_HALF: w_load_data = {{16{r_sext & w_half[15]}}, w_half};
            SZ_BYTE: w_load_data = {{24{r_sext & w_byte[7]}}, w_byte};
            default: w_load_data = w_rd_src;
        endcase
    end

    // Outputs are forced low while rst is high so a response pending at the
    // moment of reset is dropped in the same cycle.
    assign bus.rsp_valid = !rst && (r_state == ST_RESP);
    assign bus.rsp_err   = bus.rsp_valid && r_err;
    assign bus.rsp_rdata = (bus.rsp_valid && !r_err && !r_we) ? w_load_data : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_sync_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_sync_port
// Description : Directed self-checking bench for dmem_sync_port. One
//               instance with READ_LAT=1 carries most traffic; a second
//               with READ_LAT=2 checks the longer read pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_sync_port;
    import dmem_pkg::*;

    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    dmem_sync_port_if b1 ();
    dmem_sync_port_if b2 ();

    dmem_sync_port #(.DEPTH_WORDS(DEPTH), .READ_LAT(1), .INIT_FILE("")) u_lat1 (
        .clk (clk), .rst (rst), .bus (b1.slave)
    );
    dmem_sync_port #(.DEPTH_WORDS(DEPTH), .READ_LAT(2), .INIT_FILE("")) u_lat2 (
        .clk (clk), .rst (rst), .bus (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on the READ_LAT=1 port; checks latency, rdata and err.
    task automatic acc1(input string tag, input logic we, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        logic seen;
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = we; b1.req_size = sz;
        b1.req_sext = sx; b1.req_addr = a; b1.req_wdata = wd;
        @(posedge clk);
        #1;
        b1.req_valid = 1'b0;
        // Scramble fields after accept; they must be ignored.
        b1.req_size = 2'b11; b1.req_sext = ~sx; b1.req_addr = 32'hffff_fff1;
        b1.req_wdata = 32'h0;
        seen = 1'b0;
        lat  = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (!seen && b1.rsp_valid) begin
                seen = 1'b1;
                lat  = k;
                chk({tag, "_rdata"}, b1.rsp_rdata, exp_rd);
                chk({tag, "_err"}, {31'b0, b1.rsp_err}, {31'b0, exp_err});
                break;
            end
        end
        chk({tag, "_latency"}, lat, 1);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_size = SZ_WORD;
        b1.req_sext = 1'b0; b1.req_addr = 32'h0; b1.req_wdata = 32'h0;
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_size = SZ_WORD;
        b2.req_sext = 1'b0; b2.req_addr = 32'h0; b2.req_wdata = 32'h0;

        // 1. Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, b1.rsp_valid}, 32'd0);
        chk("rst_rdata", b1.rsp_rdata, 32'h0);
        chk("rst_err",   {31'b0, b1.rsp_err}, 32'd0);
        chk("rst_ready", {31'b0, b1.req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'b0, b1.req_ready}, 32'd1);
        chk("idle_valid", {31'b0, b1.rsp_valid}, 32'd0);
        chk("idle_ready2", {31'b0, b2.req_ready}, 32'd1);

        // 2. Word store/load and extensions
        acc1("sw10",  1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8badf00d, 32'h0, 1'b0);
        acc1("lw10",  1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8badf00d, 1'b0);
        acc1("lb13",  1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'hffffff8b, 1'b0);
        acc1("lbu13", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h0000008b, 1'b0);
        acc1("lh10",  1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 32'hfffff00d, 1'b0);
        acc1("lhu12", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 32'h00008bad, 1'b0);
        acc1("lw_sx", 1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, 32'h8badf00d, 1'b0);

        // 3. Partial stores preserve other lanes
        acc1("sb11",  1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hffffff5a, 32'h0, 1'b0);
        acc1("lw_sb", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h8bad5a0d, 1'b0);
        acc1("sh12",  1'b1, SZ_HALF, 1'b0, 32'h12, 32'habcd1234, 32'h0, 1'b0);
        acc1("lw_sh", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h12345a0d, 1'b0);

        // 4. Error cases
        acc1("e_lw02",  1'b0, SZ_WORD, 1'b0, 32'h02, 32'h0, 32'h0, 1'b1);
        acc1("e_sh05",  1'b1, SZ_HALF, 1'b0, 32'h05, 32'hdead, 32'h0, 1'b1);
        acc1("e_sz11",  1'b0, SZ_ILL,  1'b0, 32'h00, 32'h0, 32'h0, 1'b1);
        acc1("e_oor",   1'b0, SZ_WORD, 1'b0, 32'(4*DEPTH), 32'h0, 32'h0, 1'b1);
        acc1("e_sw12",  1'b1, SZ_WORD, 1'b0, 32'h12, 32'hdeadbeef, 32'h0, 1'b1);
        acc1("e_sw50",  1'b1, SZ_WORD, 1'b0, 32'h50, 32'hdeadbeef, 32'h0, 1'b1);
        acc1("lw_keep", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'h12345a0d, 1'b0);

        // 5a. READ_LAT=2 timing
        @(negedge clk);
        b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_size = SZ_WORD;
        b2.req_addr = 32'h20; b2.req_wdata = 32'hcafebabe;
        @(posedge clk); #1; b2.req_valid = 1'b0;
        @(negedge clk);
        chk("l2_sw_valid", {31'b0, b2.rsp_valid}, 32'd1);
        b2.req_valid = 1'b1; b2.req_we = 1'b0; b2.req_addr = 32'h20;
        @(posedge clk); #1; b2.req_valid = 1'b0; b2.req_addr = 32'h0;
        @(negedge clk);
        chk("l2_t1_ready", {31'b0, b2.req_ready}, 32'd0);
        chk("l2_t1_valid", {31'b0, b2.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("l2_t2_valid", {31'b0, b2.rsp_valid}, 32'd1);
        chk("l2_t2_rdata", b2.rsp_rdata, 32'hcafebabe);
        chk("l2_t2_ready", {31'b0, b2.req_ready}, 32'd1);
        @(negedge clk);
        chk("l2_t3_valid", {31'b0, b2.rsp_valid}, 32'd0);

        // 5b. Back-to-back stores, one response per cycle
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_size = SZ_WORD;
        b1.req_addr = 32'h00; b1.req_wdata = 32'h11111111;
        @(negedge clk);
        chk("b2b_v1", {31'b0, b1.rsp_valid}, 32'd1);
        b1.req_addr = 32'h04; b1.req_wdata = 32'h22222222;
        @(negedge clk);
        chk("b2b_v2", {31'b0, b1.rsp_valid}, 32'd1);
        b1.req_addr = 32'h08; b1.req_wdata = 32'h33333333;
        @(negedge clk);
        chk("b2b_v3", {31'b0, b1.rsp_valid}, 32'd1);
        b1.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_end", {31'b0, b1.rsp_valid}, 32'd0);
        acc1("b2b_r0", 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, 32'h11111111, 1'b0);
        acc1("b2b_r1", 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, 32'h22222222, 1'b0);
        acc1("b2b_r2", 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 32'h33333333, 1'b0);

        // 6. Reset during an access
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_size = SZ_WORD;
        b1.req_addr = 32'h10;
        @(posedge clk); #1; b1.req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_ld_valid", {31'b0, b1.rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ld_after", {31'b0, b1.rsp_valid}, 32'd0);

        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_size = SZ_WORD;
        b1.req_addr = 32'h24; b1.req_wdata = 32'h0badcafe;
        @(posedge clk); #1; b1.req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rst_st_valid", {31'b0, b1.rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        acc1("rst_st_keep", 1'b0, SZ_WORD, 1'b0, 32'h24, 32'h0, 32'h0badcafe, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
